// File: rtl/wb_master_sequencer_pkg.sv
// rtl/wb_master_sequencer_pkg.sv - shared types and constants for the wb master sequencer
// Purpose : FSM state encoding, default parameters and the index-width helper
//           used by wb_master_sequencer and its round-robin arbiter.
// Ports   : none (package).
package wb_master_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_RESPOND    = 3'd4,
        ST_DRAIN      = 3'd5
    } seq_state_e;

    localparam int unsigned DEFAULT_NUM_REQ = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 256;

    // Width of a requester index; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick
// Purpose : choose the lowest requesting index at or after ptr, wrapping
//           around to index 0, and report it one-hot and as a binary index.
// Ports   : req  [N-1:0]  request vector
//           ptr  [IW-1:0] first index with priority this cycle
//           gnt  [N-1:0]  one-hot winner (all zero when nobody requests)
//           idx  [IW-1:0] binary winner index (0 when nobody requests)
//           any           at least one request present
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Two passes replace a modulo rotation: first the indices at or above
    // ptr, then the wrapped-around indices below it.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!any && req[i] && (IW'(i) >= ptr)) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!any && req[i] && (IW'(i) < ptr)) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_master_sequencer.sv
// rtl/wb_master_sequencer.sv - round-robin sequencer sharing one wb_master_interface
// Purpose : serialise single-word read/write requests from NUM_REQ requesters
//           onto the start/address/selection/write/data_wr command port, follow
//           each transaction through active, and return data or timeout status.
// Ports   : wb_clk, wb_rst (async, active-low)
//           req_valid/req_write/req_addr/req_sel/req_wdata  requester inputs
//           req_ready   one-hot acceptance pulse
//           rsp_valid/rsp_err/rsp_rdata  completion to the granted requester
//           start/address/selection/write/data_wr  command to the master
//           active/data_rd  status and read data from the master
//           busy        sequencer not idle
module wb_master_sequencer
    import wb_master_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*4-1:0]  req_sel,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic                  start,
    output logic [31:0]           address,
    output logic [3:0]            selection,
    output logic                  write,
    output logic [31:0]           data_wr,
    input  logic                  active,
    input  logic [31:0]           data_rd,
    output logic                  busy
);

    localparam int unsigned IW      = idx_width(NUM_REQ);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    seq_state_e    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [31:0]   address_q, address_d;
    logic [3:0]    sel_q, sel_d;
    logic          write_q, write_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    logic [31:0] pick_addr;
    logic [3:0]  pick_sel;
    logic        pick_write;
    logic [31:0] pick_wdata;

    logic [15:0] cnt_inc;
    logic        timeout_hit;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Fields of the arbitration winner.
    always_comb begin
        pick_addr  = '0;
        pick_sel   = '0;
        pick_write = 1'b0;
        pick_wdata = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (arb_gnt[i]) begin
                pick_addr  = req_addr[32*i +: 32];
                pick_sel   = req_sel[4*i +: 4];
                pick_write = req_write[i];
                pick_wdata = req_wdata[32*i +: 32];
            end
        end
    end

    // Saturating increment. The wait ends in the cycle the counter is
    // written with TIMEOUT-1, so RESPOND lands TIMEOUT cycles after start.
    always_comb begin
        cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        timeout_hit = (cnt_inc >= TO_LAST);
    end

    // State and datapath registers.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            cnt_q     <= '0;
            address_q <= '0;
            sel_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            cnt_q     <= cnt_d;
            address_q <= address_d;
            sel_q     <= sel_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Next state. Normal progress of the master wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (arb_any) state_d = ST_ISSUE;
            ST_ISSUE:      state_d = ST_WAIT_START;
            ST_WAIT_START: begin
                if (active)           state_d = ST_WAIT_DONE;
                else if (timeout_hit) state_d = ST_RESPOND;
            end
            ST_WAIT_DONE:  begin
                if (!active)          state_d = ST_RESPOND;
                else if (timeout_hit) state_d = ST_RESPOND;
            end
            ST_RESPOND:    state_d = (err_q && active) ? ST_DRAIN : ST_IDLE;
            ST_DRAIN:      if (!active) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Command registers, grant bookkeeping, timeout counter and response data.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        cnt_d     = cnt_q;
        address_d = address_q;
        sel_d     = sel_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    address_d = pick_addr;
                    sel_d     = pick_sel;
                    write_d   = pick_write;
                    wdata_d   = pick_wdata;
                    gnt_idx_d = arb_idx;
                    rr_ptr_d  = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                end
            end
            ST_ISSUE: cnt_d = '0;
            ST_WAIT_START: begin
                cnt_d = cnt_inc;
                if (!active && timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_inc;
                if (!active) begin
                    err_d   = 1'b0;
                    rdata_d = write_q ? 32'd0 : data_rd;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Outputs. req_ready is a Mealy output of IDLE; it is masked by the reset
    // so every output reads 0 while wb_rst is held low.
    always_comb begin
        req_ready = (state_q == ST_IDLE && wb_rst) ? arb_gnt : '0;
        rsp_valid = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            rsp_valid[i] = (state_q == ST_RESPOND) && (gnt_idx_q == IW'(i));
        end
        rsp_err   = (state_q == ST_RESPOND) && err_q;
        rsp_rdata = rdata_q;
        start     = (state_q == ST_ISSUE);
        address   = address_q;
        selection = sel_q;
        write     = write_q;
        data_wr   = wdata_q;
        busy      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_wb_master_sequencer.sv
// tb/tb_wb_master_sequencer.sv - self-checking bench for wb_master_sequencer
module tb_wb_master_sequencer;

    localparam int N  = 4;
    localparam int TO = 16;

    logic            wb_clk = 1'b0;
    logic            wb_rst;
    logic [N-1:0]    req_valid, req_write;
    logic [N*32-1:0] req_addr, req_wdata;
    logic [N*4-1:0]  req_sel;
    logic [N-1:0]    req_ready, rsp_valid;
    logic            rsp_err;
    logic [31:0]     rsp_rdata;
    logic            start;
    logic [31:0]     address;
    logic [3:0]      selection;
    logic            write;
    logic [31:0]     data_wr;
    logic            active;
    logic [31:0]     data_rd;
    logic            busy;

    logic slave_act, man_act, slave_en, slave_fast;
    assign active = slave_act | man_act;

    always #5 wb_clk = ~wb_clk;

    wb_master_sequencer #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_sel(req_sel), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .start(start), .address(address), .selection(selection), .write(write),
        .data_wr(data_wr), .active(active), .data_rd(data_rd), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory behind the bus, shared by the fake master and the checks.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    // Fake wb_master_interface: active rises 1+dly cycles after start, stays
    // high len cycles, data_rd is presented as it falls.
    initial begin
        slave_act = 1'b0;
        data_rd   = '0;
        forever begin : slave_loop
            int dly, len;
            logic [31:0] m;
            @(negedge wb_clk);
            if (slave_en && wb_rst && start) begin
                dly = slave_fast ? 0 : $urandom_range(0, 2);
                len = slave_fast ? 1 : $urandom_range(1, 3);
                repeat (dly + 1) @(posedge wb_clk);
                #1 slave_act = 1'b1;
                repeat (len) @(posedge wb_clk);
                #1 slave_act = 1'b0;
                if (write) begin
                    m = mem_rd(address);
                    for (int b = 0; b < 4; b++) if (selection[b]) m[8*b +: 8] = data_wr[8*b +: 8];
                    mem[address] = m;
                    data_rd = $urandom;
                end else begin
                    data_rd = mem_rd(address);
                end
            end
        end
    end

    // Behavioural reference: a transaction record with the cycle numbers at
    // which start and the response must appear.
    int          cyc = 0;
    int          m_rr = 0;
    bit          m_tx = 0;
    int          m_gnt = 0, m_t0 = 0, m_resp = -1;
    bit          m_seen = 0, m_err = 0, m_drain = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_sel = '0;
    logic        m_wr = 1'b0;
    logic [N-1:0] rdy_seen = '0;
    int          start_cnt = 0;

    always @(negedge wb_clk) begin : cmp_p
        int w;
        logic [N-1:0] er, ev;
        cyc++;
        if (!wb_rst) begin
            m_rr = 0; m_tx = 0; m_resp = -1; m_drain = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_sel = '0; m_wr = 1'b0;
            chk("reset_ctl", {req_ready, rsp_valid, rsp_err, start, busy, write, selection}, 0);
            chk("reset_data", {address, data_wr}, 0);
            chk("reset_rdata", rsp_rdata, 0);
        end else begin
            w = -1;
            if (!m_tx)
                for (int k = 0; k < N; k++)
                    if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
            er = (w >= 0) ? N'(1 << w) : '0;
            ev = (m_tx && cyc == m_resp) ? N'(1 << m_gnt) : '0;
            chk("req_ready", req_ready, er);
            chk("start", start, m_tx && cyc == m_t0);
            chk("rsp_valid", rsp_valid, ev);
            chk("rsp_err", rsp_err, m_tx && cyc == m_resp && m_err);
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("busy", busy, m_tx);
            chk("cmd", {address, data_wr}, {m_addr, m_wdata});
            chk("cmd_ctl", {selection, write}, {m_sel, m_wr});
            if (start) start_cnt++;
            if (!m_tx) begin
                if (w >= 0) begin
                    m_tx = 1; m_gnt = w; m_t0 = cyc + 1; m_rr = (w + 1) % N;
                    m_seen = 0; m_resp = -1; m_err = 0; m_drain = 0;
                    m_addr = req_addr[32*w +: 32]; m_wdata = req_wdata[32*w +: 32];
                    m_sel = req_sel[4*w +: 4]; m_wr = req_write[w];
                end
            end else if (m_drain) begin
                if (!active) m_tx = 0;
            end else if (cyc == m_resp) begin
                if (m_err && active) m_drain = 1;
                else m_tx = 0;
            end else if (m_resp < 0 && cyc > m_t0) begin
                if (!m_seen && active) m_seen = 1;
                else if (m_seen && !active) begin
                    m_resp = cyc + 1; m_err = 0; m_rdata = m_wr ? 32'd0 : data_rd;
                end else if (cyc >= m_t0 + TO - 1) begin
                    m_resp = cyc + 1; m_err = 1; m_rdata = '0;
                end
            end
        end
        rdy_seen = req_ready;
    end

    logic [31:0] pool [4] = '{32'h2000_0000, 32'h3000_0000, 32'h9000_0000, 32'hA000_0000};

    task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d);
        req_valid[i] = 1'b1; req_write[i] = wr; req_addr[32*i +: 32] = a;
        req_sel[4*i +: 4] = s; req_wdata[32*i +: 32] = d;
    endtask

    task automatic new_req(input int i);
        set_req(i, 1'($urandom % 2), pool[$urandom % 4] + 32'(($urandom % 4) * 4),
                4'($urandom_range(1, 15)), $urandom);
    endtask

    // One request from requester i; returns ready, response and the number
    // of cycles from acceptance to response.
    task automatic do_req(input int i, input logic wr, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output logic [N-1:0] rdy, output logic [N-1:0] rsp,
                          output logic err, output logic [31:0] rd, output int lat);
        int t;
        rdy = '0; rsp = '0; err = 1'b0; rd = '0; lat = 0;
        @(posedge wb_clk); #1 set_req(i, wr, a, s, d);
        t = 0;
        do begin @(negedge wb_clk); t++; end while (req_ready == 0 && t < 100);
        rdy = req_ready;
        if (t >= 100) chk("do_req_grant_wait", 0, 1);
        @(posedge wb_clk); #1 req_valid[i] = 1'b0;
        t = 0;
        do begin @(negedge wb_clk); t++; end while (rsp_valid == 0 && t < 100);
        if (t >= 100) chk("do_req_rsp_wait", 0, 1);
        rsp = rsp_valid; err = rsp_err; rd = rsp_rdata; lat = t;
    endtask

    // Collect grants; requester i drops its request after quota[i] grants.
    task automatic collect(input int quota [N], input int total, output logic [15:0] order);
        int got, t;
        int cnt [N];
        logic [N-1:0] r;
        order = '0; got = 0; t = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        while (got < total && t < 400) begin
            @(negedge wb_clk); t++;
            r = req_ready;
            @(posedge wb_clk); #1;
            for (int i = 0; i < N; i++) if (r[i]) begin
                order = {order[11:0], 4'(i)};
                got++; cnt[i]++;
                if (cnt[i] >= quota[i]) req_valid[i] = 1'b0;
            end
        end
        if (got < total) chk("collect_wait", 0, 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin @(negedge wb_clk); t++; end while (busy && t < 200);
        if (t >= 200) chk("wait_idle", 0, 1);
    endtask

    task automatic wait_start();
        int t;
        t = 0;
        do begin @(negedge wb_clk); t++; end while (!start && t < 100);
        if (t >= 100) chk("wait_start", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [N-1:0] rdy, rsp;
        logic err;
        logic [31:0] rd;
        logic [15:0] order;
        int lat, s0, k;
        int q_all [N];
        int q_fair [N];

        wb_rst = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_sel = '0;
        req_wdata = '0; man_act = 1'b0; slave_en = 1'b1; slave_fast = 1'b1;
        repeat (3) @(posedge wb_clk);
        #1 chk("rst_outs", {req_ready, rsp_valid, rsp_err, start, busy, selection, write}, 0);
        chk("rst_cmd", {address, data_wr}, 0);
        wb_rst = 1'b1;

        // Single write, best-case turnaround.
        s0 = start_cnt;
        do_req(0, 1'b1, 32'h2000_0000, 4'hF, 32'hA5A5_B6B6, rdy, rsp, err, rd, lat);
        chk("t1_ready", rdy, 4'b0001);
        chk("t1_rsp", rsp, 4'b0001);
        chk("t1_err", err, 0);
        chk("t1_turnaround", lat, 4);
        chk("t1_starts", start_cnt - s0, 1);
        chk("t1_mem", mem_rd(32'h2000_0000), 32'hA5A5_B6B6);
        wait_idle();

        // Read-back by requester 2.
        do_req(2, 1'b0, 32'h2000_0000, 4'hF, 32'h0, rdy, rsp, err, rd, lat);
        chk("t2_rsp", rsp, 4'b0100);
        chk("t2_rdata", rd, 32'hA5A5_B6B6);
        chk("t2_err", err, 0);
        wait_idle();

        // Reset to bring rr_ptr back to 0, then all four contend.
        @(posedge wb_clk); #1 wb_rst = 1'b0;
        @(posedge wb_clk); #1 wb_rst = 1'b1;
        slave_fast = 1'b0;
        s0 = start_cnt;
        @(posedge wb_clk); #1;
        set_req(0, 1'b1, 32'h2000_0000, 4'hF, 32'h1111_0000);
        set_req(1, 1'b1, 32'h3000_0000, 4'hF, 32'h2222_0001);
        set_req(2, 1'b1, 32'h9000_0000, 4'hF, 32'h3333_0002);
        set_req(3, 1'b1, 32'hA000_0000, 4'h3, 32'h4444_0003);
        q_all = '{1, 1, 1, 1};
        collect(q_all, 4, order);
        wait_idle();
        chk("t3_order", order, 16'h0123);
        chk("t3_starts", start_cnt - s0, 4);
        chk("t3_mem0", mem_rd(32'h2000_0000), 32'h1111_0000);
        chk("t3_mem1", mem_rd(32'h3000_0000), 32'h2222_0001);
        chk("t3_mem2", mem_rd(32'h9000_0000), 32'h3333_0002);
        chk("t3_mem3", mem_rd(32'hA000_0000), 32'h5FFF_0003);

        // Fairness: 0 re-requests at once while 1 is pending.
        @(posedge wb_clk); #1;
        set_req(0, 1'b0, 32'h3000_0000, 4'hF, 32'h0);
        set_req(1, 1'b0, 32'h9000_0000, 4'hF, 32'h0);
        q_fair = '{2, 1, 1, 1};
        collect(q_fair, 3, order);
        wait_idle();
        chk("t4_order", order[11:0], 12'h010);

        // Timeout: master holds active high.
        slave_en = 1'b0;
        @(posedge wb_clk); #1 set_req(3, 1'b0, 32'h9000_0000, 4'hF, 32'h0);
        wait_start();
        @(posedge wb_clk); #1 man_act = 1'b1; req_valid[3] = 1'b0;
        k = 1;
        while (rsp_valid == 0 && k < 60) begin @(negedge wb_clk); if (rsp_valid == 0) k++; end
        chk("t5_delay", k, 16);
        chk("t5_rsp", rsp_valid, 4'b1000);
        chk("t5_err", rsp_err, 1);
        chk("t5_rdata", rsp_rdata, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk);
            chk("t5_drain", {busy, start}, 2'b10);
        end
        @(posedge wb_clk); #1 man_act = 1'b0;
        @(negedge wb_clk);
        @(negedge wb_clk);
        chk("t5_idle", busy, 0);

        // Reset in WAIT_DONE.
        @(posedge wb_clk); #1 set_req(1, 1'b0, 32'h2000_0000, 4'hF, 32'h0);
        wait_start();
        @(posedge wb_clk); #1 man_act = 1'b1; req_valid[1] = 1'b0;
        repeat (3) @(posedge wb_clk);
        #3 wb_rst = 1'b0;
        #1 chk("t6_ctl", {req_ready, rsp_valid, rsp_err, start, busy, selection, write}, 0);
        chk("t6_cmd", {address, data_wr}, 0);
        chk("t6_rdata", rsp_rdata, 0);
        @(posedge wb_clk); #1 man_act = 1'b0;
        @(posedge wb_clk); #1 wb_rst = 1'b1;
        slave_en = 1'b1;
        do_req(1, 1'b1, 32'h3000_0000, 4'hC, 32'hBEEF_0000, rdy, rsp, err, rd, lat);
        chk("t6_rsp", rsp, 4'b0010);
        chk("t6_err", err, 0);
        chk("t6_mem", mem_rd(32'h3000_0000), 32'hBEEF_0001);
        wait_idle();

        // Randomised traffic against the reference.
        for (int c = 0; c < 3000; c++) begin
            @(posedge wb_clk); #1;
            for (int i = 0; i < N; i++) begin
                if (rdy_seen[i]) begin
                    if ($urandom % 2 == 0) new_req(i);
                    else req_valid[i] = 1'b0;
                end else if (req_valid[i] && $urandom % 16 == 0) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom % 4 == 0) new_req(i);
            end
        end
        @(posedge wb_clk); #1 req_valid = '0;
        wait_idle();
        repeat (2) @(negedge wb_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_master_sequencer.md
# wb_master_sequencer

Round-robin scheduler that shares one `wb_master_interface` between up to `NUM_REQ` internal requesters, such as DSP channels and DAQ engines. It serialises single-word read/write requests and drives the interface's `start/address/selection/write/data_wr` command port. It tracks each transaction through `active` and returns read data or error status to the requester that issued it. It sits directly between the DSP datapath clients and the DAQ Wishbone master port on the bus matrix.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 256: cycles from `start` to forced completion; 16-bit counter.
- `wb_clk` in 1: clock.
- `wb_rst` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester request; held with its fields until `req_ready`.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*32: byte address, requester i at [32i+31:32i].
- `req_sel` in NUM_REQ*4: byte selects.
- `req_wdata` in NUM_REQ*32: write data.
- `req_ready` out NUM_REQ: one-cycle acceptance pulse, one-hot.
- `rsp_valid` out NUM_REQ: one-cycle completion pulse, one-hot, to the granted requester.
- `rsp_err` out 1: qualifies `rsp_valid`; 1 = timeout.
- `rsp_rdata` out 32: read data, valid with `rsp_valid`. It is 0 for writes and timeouts.
- `start` out 1: one-cycle command strobe to `wb_master_interface`.
- `address`, `selection`, `write`, `data_wr` out 32/4/1/32: registered command fields, stable from `start` until return to IDLE.
- `active` in 1: transaction in progress from `wb_master_interface`.
- `data_rd` in 32: read data from `wb_master_interface`.
- `busy` out 1: state != IDLE.

## Operation
- States are IDLE, ISSUE, WAIT_START, WAIT_DONE, RESPOND and DRAIN.
- **IDLE**
  - If any `req_valid` is set, pick the winner round-robin starting at `rr_ptr`.
  - Latch its fields into the command registers and store its index in `gnt_idx`.
  - Pulse `req_ready[gnt_idx]`, set `rr_ptr = (gnt_idx+1) mod NUM_REQ`, and go to ISSUE.
- **ISSUE**: `start=1` for exactly this cycle. Clear the timeout counter and go to WAIT_START.
- **WAIT_START**
  - `active=1` → WAIT_DONE.
  - Counter reaches TIMEOUT-1 → RESPOND with error.
- **WAIT_DONE**
  - `active` falls to 0 → capture `data_rd` if read, else 0, then go to RESPOND.
  - Counter reaches TIMEOUT-1 → RESPOND with error.
- **RESPOND**
  - `rsp_valid[gnt_idx]=1` with `rsp_err` and `rsp_rdata`.
  - If error and `active=1`, go to DRAIN; otherwise go to IDLE.
- **DRAIN**: wait for `active=0`, then go to IDLE. No new command is issued while the master is still busy.
- The timeout counter saturates and increments every cycle in WAIT_START and WAIT_DONE.
- Requests arriving outside IDLE wait. A requester may deassert `req_valid` before grant without side effects.
- Simultaneous requests: the lowest index at or after `rr_ptr` (wrapping) wins. Each requester gets at most one grant per NUM_REQ grants while the others request.

## Timing
- Reset values:
  - All outputs are 0.
  - `rr_ptr`, `gnt_idx` and the counter are 0; state is IDLE.
- Request at cycle N in IDLE:
  - `req_ready` at N.
  - `start` at N+1.
- Best-case turnaround is 5 cycles from `req_valid` to the next grant:
  - `active` rises at N+2 and falls at N+3.
  - `rsp_valid` is at N+4.
  - The next grant is at N+5.
- Reset mid-transaction: state returns to IDLE immediately and no response is issued. The requester re-requests after reset.
- `rsp_rdata` is held until the next RESPOND.

## Structure
- Package `wb_master_sequencer_pkg`: state enum/encoding, default `TIMEOUT`, and index width `$clog2(NUM_REQ)`.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req_valid` and `rr_ptr`, producing a one-hot grant and index. It is reused by future DMA blocks.
- FSM, command registers and timeout counter live in the top.

## Test plan
- Single write: requester 0 writes 0xA5A5B6B6 to 0x20000000 with sel 0xF → one `start`, `rsp_valid[0]`, `rsp_err=0`, and ram0 mem[0]=0xA5A5B6B6.
- Read-back: requester 2 reads 0x20000000 → `rsp_valid[2]`, `rsp_rdata=0xA5A5B6B6`.
- Contention: all 4 request at once with writes to 0x20000000/0x30000000/0x90000000/0xA0000000 → grants in order 0,1,2,3, four `start` pulses, no overlap, and all RAMs correct.
- Fairness: requester 0 re-requests immediately while 1 is pending → grant order 0,1,0 with `rr_ptr` wrapping.
- Timeout: `active` forced high with TIMEOUT=16 → `rsp_err=1` on the 16th cycle after `start`, then DRAIN until `active` drops, with no `start` during DRAIN.
- Reset mid-WAIT_DONE: assert `wb_rst=0` → all outputs 0 asynchronously. After release, a fresh request completes normally.
